// File: rtl/instr_encoder_if.sv
// Field-bundle input, instruction-memory write port and status flags of instr_encoder.
// Latency: none, wiring only.
// Backpressure: in_valid/in_ready on the field side, mem_we held until mem_ack on the memory side.
interface instr_encoder_if #(
  parameter int ADDR_W = 8
);
  // field bundle from the program source
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        op;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [31:0]       imm;
  logic              last;

  // instruction memory write port
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;

  // program progress and sticky status
  logic [ADDR_W:0]   count;
  logic              done;
  logic              bad_op;
  logic              imm_err;
  logic              full;

  // program source and memory model side
  modport master (
    output in_valid, op, rd, rs1, rs2, funct3, funct7, imm, last, mem_ack,
    input  in_ready, mem_we, mem_addr, mem_wdata, count, done, bad_op, imm_err, full
  );

  // encoder side
  modport slave (
    input  in_valid, op, rd, rs1, rs2, funct3, funct7, imm, last, mem_ack,
    output in_ready, mem_we, mem_addr, mem_wdata, count, done, bad_op, imm_err, full
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs opcode/register/funct/immediate fields into RV32I words and writes them to sequential addresses.
// Latency: mem_we rises the cycle after a bundle is accepted; with an immediate ack one word per 2 cycles.
// Backpressure: in_ready drops while a word waits for mem_ack; optional IMM_RANGE_CHECK_EN adds imm_err checking.
module instr_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic            clk,
  input  logic            reset,
  instr_encoder_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2,
    S_FULL  = 2'd3
  } state_t;

  // instruction layout class; I..U match the immediate-source decoder encoding
  typedef enum logic [2:0] {
    FMT_I = 3'b000,
    FMT_S = 3'b001,
    FMT_B = 3'b010,
    FMT_J = 3'b011,
    FMT_U = 3'b100,
    FMT_R = 3'b101
  } fmt_t;

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              last_q, last_d;
  logic              bad_op_q, bad_op_d;
  logic              full_q, full_d;

  fmt_t              fmt;
  logic              op_unknown;
  logic [31:0]       enc_word;

  // classify the incoming opcode; unknown opcodes fall back to the R layout
  always_comb begin
    fmt        = FMT_R;
    op_unknown = 1'b0;
    case (bus.op)
      7'b0000011, 7'b0010011, 7'b1100111: fmt = FMT_I;
      7'b0100011:                         fmt = FMT_S;
      7'b1100011:                         fmt = FMT_B;
      7'b1101111:                         fmt = FMT_J;
      7'b0110111, 7'b0010111:             fmt = FMT_U;
      7'b0110011:                         fmt = FMT_R;
      default: begin
        fmt        = FMT_R;
        op_unknown = 1'b1;
      end
    endcase
  end

  // pack the fields; immediates are truncated to the bits each layout carries
  always_comb begin
    enc_word = 32'd0;
    case (fmt)
      FMT_I: enc_word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.op};
      FMT_S: enc_word = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.op};
      FMT_B: enc_word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                         bus.imm[4:1], bus.imm[11], bus.op};
      FMT_J: enc_word = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12], bus.rd, bus.op};
      FMT_U: enc_word = {bus.imm[31:12], bus.rd, bus.op};
      default: enc_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.op};
    endcase
  end

  // sequencing: accept in IDLE, hold the word until acked, then advance or finish the program
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    count_d  = count_q;
    last_d   = last_q;
    bad_op_d = bad_op_q;
    full_d   = full_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          wdata_d  = enc_word;
          last_d   = bus.last;
          bad_op_d = bad_op_q | op_unknown;
          state_d  = S_WRITE;
        end
      end
      S_WRITE: begin
        if (bus.mem_ack) begin
          addr_d  = addr_q + ADDR_ONE;
          count_d = count_q + CNT_ONE;
          if (last_q) begin
            state_d = S_DONE;
          end else if (addr_q == ADDR_MAX) begin
            state_d = S_FULL;
            full_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DONE: begin
        addr_d  = BASE;
        count_d = '0;
        state_d = S_IDLE;
      end
      S_FULL: begin
        state_d = S_FULL;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= BASE;
      wdata_q  <= 32'd0;
      count_q  <= '0;
      last_q   <= 1'b0;
      bad_op_q <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      count_q  <= count_d;
      last_q   <= last_d;
      bad_op_q <= bad_op_d;
      full_q   <= full_d;
    end
  end

`ifdef IMM_RANGE_CHECK_EN
  logic imm_bad;
  logic imm_err_q, imm_err_d;

  // immediate must be representable by the layout it is packed into
  always_comb begin
    imm_bad = 1'b0;
    case (fmt)
      FMT_I, FMT_S: imm_bad = !((&bus.imm[31:11]) || !(|bus.imm[31:11]));
      FMT_B:        imm_bad = !((&bus.imm[31:12]) || !(|bus.imm[31:12])) || bus.imm[0];
      FMT_J:        imm_bad = !((&bus.imm[31:20]) || !(|bus.imm[31:20])) || bus.imm[0];
      FMT_U:        imm_bad = |bus.imm[11:0];
      default:      imm_bad = 1'b0;
    endcase
  end

  // sticky range error, raised when an offending bundle is accepted
  always_comb begin
    imm_err_d = imm_err_q;
    if (state_q == S_IDLE && bus.in_valid && imm_bad) begin
      imm_err_d = 1'b1;
    end
  end

  // range error register
  always_ff @(posedge clk) begin
    if (reset) begin
      imm_err_q <= 1'b0;
    end else begin
      imm_err_q <= imm_err_d;
    end
  end

  assign bus.imm_err = imm_err_q;
`else
  assign bus.imm_err = 1'b0;
`endif

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.mem_we    = (state_q == S_WRITE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.count     = count_q;
  assign bus.done      = (state_q == S_DONE);
  assign bus.bad_op    = bad_op_q;
  assign bus.full      = full_q;

endmodule
